// File: rtl/tl_uncached_pkg.sv
// Shared TileLink uncached field widths and packed channel types.
package tl_uncached_pkg;

  localparam int unsigned ADDR_BLOCK_W = 26;
  localparam int unsigned BEAT_W       = 3;
  localparam int unsigned CLIENT_ID_W  = 1;
  localparam int unsigned MGR_ID_W     = 2;
  localparam int unsigned A_TYPE_W     = 3;
  localparam int unsigned UNION_W      = 12;
  localparam int unsigned G_TYPE_W     = 4;
  localparam int unsigned DATA_W       = 64;
  localparam int unsigned COUNT_W      = 4;

  localparam int unsigned ACQ_W = ADDR_BLOCK_W + CLIENT_ID_W + BEAT_W + 1 + A_TYPE_W + UNION_W + DATA_W;
  localparam int unsigned GNT_W = BEAT_W + CLIENT_ID_W + MGR_ID_W + 1 + G_TYPE_W + DATA_W;

  typedef struct packed {
    logic [ADDR_BLOCK_W-1:0] addr_block;
    logic [CLIENT_ID_W-1:0]  client_xact_id;
    logic [BEAT_W-1:0]       addr_beat;
    logic                    is_builtin_type;
    logic [A_TYPE_W-1:0]     a_type;
    logic [UNION_W-1:0]      union_bits;
    logic [DATA_W-1:0]       data;
  } acq_t;

  typedef struct packed {
    logic [BEAT_W-1:0]       addr_beat;
    logic [CLIENT_ID_W-1:0]  client_xact_id;
    logic [MGR_ID_W-1:0]     manager_xact_id;
    logic                    is_builtin_type;
    logic [G_TYPE_W-1:0]     g_type;
    logic [DATA_W-1:0]       data;
  } gnt_t;

endpackage

// File: rtl/tl_fifo.sv
// Registered ready/valid circular FIFO; pointers wrap at DEPTH, no bypass paths.
module tl_fifo
  import tl_uncached_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_bits,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_bits,
  output logic [COUNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [COUNT_W-1:0] cnt;
  logic               enq;
  logic               deq;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (cnt != COUNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign out_bits  = mem[head];
  assign count     = cnt;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) tail <= next_ptr(tail);
      if (deq) head <= next_ptr(head);
      case ({enq, deq})
        2'b10:   cnt <= cnt + COUNT_W'(1);
        2'b01:   cnt <= cnt - COUNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset: contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= in_bits;
  end

endmodule

// File: rtl/tl_uncached_buffer.sv
// Decoupling buffer for the uncached TileLink port: acquire FIFO always,
// grant FIFO only when TL_UNCACHED_BUFFER_GRANT_QUEUE_EN is defined.
module tl_uncached_buffer
  import tl_uncached_pkg::*;
#(
  parameter int unsigned ACQ_DEPTH = 2,
  parameter int unsigned GNT_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    io_in_acquire_ready,
  input  logic                    io_in_acquire_valid,
  input  logic [ADDR_BLOCK_W-1:0] io_in_acquire_bits_addr_block,
  input  logic [CLIENT_ID_W-1:0]  io_in_acquire_bits_client_xact_id,
  input  logic [BEAT_W-1:0]       io_in_acquire_bits_addr_beat,
  input  logic                    io_in_acquire_bits_is_builtin_type,
  input  logic [A_TYPE_W-1:0]     io_in_acquire_bits_a_type,
  input  logic [UNION_W-1:0]      io_in_acquire_bits_union,
  input  logic [DATA_W-1:0]       io_in_acquire_bits_data,
  input  logic                    io_in_grant_ready,
  output logic                    io_in_grant_valid,
  output logic [BEAT_W-1:0]       io_in_grant_bits_addr_beat,
  output logic [CLIENT_ID_W-1:0]  io_in_grant_bits_client_xact_id,
  output logic [MGR_ID_W-1:0]     io_in_grant_bits_manager_xact_id,
  output logic                    io_in_grant_bits_is_builtin_type,
  output logic [G_TYPE_W-1:0]     io_in_grant_bits_g_type,
  output logic [DATA_W-1:0]       io_in_grant_bits_data,
  input  logic                    io_out_acquire_ready,
  output logic                    io_out_acquire_valid,
  output logic [ADDR_BLOCK_W-1:0] io_out_acquire_bits_addr_block,
  output logic [CLIENT_ID_W-1:0]  io_out_acquire_bits_client_xact_id,
  output logic [BEAT_W-1:0]       io_out_acquire_bits_addr_beat,
  output logic                    io_out_acquire_bits_is_builtin_type,
  output logic [A_TYPE_W-1:0]     io_out_acquire_bits_a_type,
  output logic [UNION_W-1:0]      io_out_acquire_bits_union,
  output logic [DATA_W-1:0]       io_out_acquire_bits_data,
  output logic                    io_out_grant_ready,
  input  logic                    io_out_grant_valid,
  input  logic [BEAT_W-1:0]       io_out_grant_bits_addr_beat,
  input  logic [CLIENT_ID_W-1:0]  io_out_grant_bits_client_xact_id,
  input  logic [MGR_ID_W-1:0]     io_out_grant_bits_manager_xact_id,
  input  logic                    io_out_grant_bits_is_builtin_type,
  input  logic [G_TYPE_W-1:0]     io_out_grant_bits_g_type,
  input  logic [DATA_W-1:0]       io_out_grant_bits_data,
  output logic [COUNT_W-1:0]      acq_count,
  output logic [COUNT_W-1:0]      gnt_count
);

  if (ACQ_DEPTH < 1 || ACQ_DEPTH > 8) begin : g_bad_acq_depth
    $error("tl_uncached_buffer: ACQ_DEPTH must be 1..8");
  end
  if (GNT_DEPTH < 1 || GNT_DEPTH > 8) begin : g_bad_gnt_depth
    $error("tl_uncached_buffer: GNT_DEPTH must be 1..8");
  end

  acq_t acq_in;
  acq_t acq_out;
  gnt_t gnt_in;
  gnt_t gnt_out;

  assign acq_in = '{
    addr_block:      io_in_acquire_bits_addr_block,
    client_xact_id:  io_in_acquire_bits_client_xact_id,
    addr_beat:       io_in_acquire_bits_addr_beat,
    is_builtin_type: io_in_acquire_bits_is_builtin_type,
    a_type:          io_in_acquire_bits_a_type,
    union_bits:      io_in_acquire_bits_union,
    data:            io_in_acquire_bits_data
  };

  tl_fifo #(.DEPTH(ACQ_DEPTH), .WIDTH(ACQ_W)) u_acq_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (io_in_acquire_valid),
    .in_ready  (io_in_acquire_ready),
    .in_bits   (acq_in),
    .out_valid (io_out_acquire_valid),
    .out_ready (io_out_acquire_ready),
    .out_bits  (acq_out),
    .count     (acq_count)
  );

  assign io_out_acquire_bits_addr_block      = acq_out.addr_block;
  assign io_out_acquire_bits_client_xact_id  = acq_out.client_xact_id;
  assign io_out_acquire_bits_addr_beat       = acq_out.addr_beat;
  assign io_out_acquire_bits_is_builtin_type = acq_out.is_builtin_type;
  assign io_out_acquire_bits_a_type          = acq_out.a_type;
  assign io_out_acquire_bits_union           = acq_out.union_bits;
  assign io_out_acquire_bits_data            = acq_out.data;

  assign gnt_in = '{
    addr_beat:       io_out_grant_bits_addr_beat,
    client_xact_id:  io_out_grant_bits_client_xact_id,
    manager_xact_id: io_out_grant_bits_manager_xact_id,
    is_builtin_type: io_out_grant_bits_is_builtin_type,
    g_type:          io_out_grant_bits_g_type,
    data:            io_out_grant_bits_data
  };

`ifdef TL_UNCACHED_BUFFER_GRANT_QUEUE_EN
  tl_fifo #(.DEPTH(GNT_DEPTH), .WIDTH(GNT_W)) u_gnt_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (io_out_grant_valid),
    .in_ready  (io_out_grant_ready),
    .in_bits   (gnt_in),
    .out_valid (io_in_grant_valid),
    .out_ready (io_in_grant_ready),
    .out_bits  (gnt_out),
    .count     (gnt_count)
  );
`else
  assign gnt_out            = gnt_in;
  assign io_in_grant_valid  = io_out_grant_valid;
  assign io_out_grant_ready = io_in_grant_ready;
  assign gnt_count          = '0;
`endif

  assign io_in_grant_bits_addr_beat       = gnt_out.addr_beat;
  assign io_in_grant_bits_client_xact_id  = gnt_out.client_xact_id;
  assign io_in_grant_bits_manager_xact_id = gnt_out.manager_xact_id;
  assign io_in_grant_bits_is_builtin_type = gnt_out.is_builtin_type;
  assign io_in_grant_bits_g_type          = gnt_out.g_type;
  assign io_in_grant_bits_data            = gnt_out.data;

endmodule
